// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath: product width, accumulator
// FSM states and a saturating signed add used by downstream summation stages.
package mult_pkg;

    localparam int PROD_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] value;
        logic        ovf;
    } sat_res_t;

    // Both operands arrive sign-extended to 32 bits; width (2..31) selects the clamp range.
    function automatic sat_res_t sat_add(input logic signed [31:0] acc,
                                         input logic signed [31:0] addend,
                                         input int                 width);
        sat_res_t           res;
        logic signed [32:0] sum;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        sum   = $signed({acc[31], acc}) + $signed({addend[31], addend});
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (width - 1));
        if (sum > max_v) begin
            res.value = max_v;
            res.ovf   = 1'b1;
        end else if (sum < min_v) begin
            res.value = min_v;
            res.ovf   = 1'b1;
        end else begin
            res.value = sum[31:0];
            res.ovf   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a frame of N_TERMS signed products into a saturating accumulator and
// holds the result behind a done/ack handshake. ACC_W must lie in 12..31.
//   state | meaning
//   IDLE  | waiting for first product of a frame; previous result still shown
//   ACCUM | frame in progress, gaps allowed
//   DONE  | result final, inputs blocked until ack_in
module product_accumulator
    import mult_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid_in,
    output logic              ready_out,
    input  logic              clear_in,
    input  logic              ack_in,
    output logic [ACC_W-1:0]  sum_out,
    output logic              done_out,
    output logic              ovf_out
);

    state_t           state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [31:0]      acc_ext;
    logic [31:0]      prod_ext;
    sat_res_t         add_res;
    logic [ACC_W-1:0] add_lo;
    logic [31-ACC_W:0] add_hi_unused;

    assign accept   = prod_valid_in & ready_out;
    assign acc_ext  = {{(32-ACC_W){sum_q[ACC_W-1]}}, sum_q};
    assign prod_ext = {{(32-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign add_res  = sat_add(acc_ext, prod_ext, ACC_W);
    assign {add_hi_unused, add_lo} = add_res.value;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sum_d   = prod_ext[ACC_W-1:0];
                    ovf_d   = 1'b0;
                    count_d = 8'd1;
                    state_d = (N_TERMS == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    sum_d   = add_lo;
                    ovf_d   = ovf_q | add_res.ovf;
                    count_d = count_q + 8'd1;
                    if (count_q == 8'(N_TERMS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (ack_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any product presented in the same cycle.
        if (clear_in) begin
            state_d = IDLE;
            count_d = 8'd0;
            sum_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_comb begin
        ready_out = (state_q != DONE);
        done_out  = (state_q == DONE);
        sum_out   = sum_q;
        ovf_out   = ovf_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a 16-bit and a 13-bit accumulator with identical stimulus and
// compares both against a frame-level arithmetic model.
module tb_product_accumulator;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] prod_in;
    logic        prod_valid_in;
    logic        clear_in;
    logic        ack_in;

    logic        ready16, done16, ovf16;
    logic [15:0] sum16;
    logic        ready13, done13, ovf13;
    logic [12:0] sum13;

    int n_checks = 0;
    int n_pass   = 0;

    int m_sum [2];
    bit m_ovf [2];
    int m_w   [2] = '{16, 13};
    bit m_done;
    int m_terms;

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(N), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid_in(prod_valid_in),
        .ready_out(ready16), .clear_in(clear_in), .ack_in(ack_in),
        .sum_out(sum16), .done_out(done16), .ovf_out(ovf16)
    );

    product_accumulator #(.N_TERMS(N), .ACC_W(13)) u_dut13 (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid_in(prod_valid_in),
        .ready_out(ready13), .clear_in(clear_in), .ack_in(ack_in),
        .sum_out(sum13), .done_out(done13), .ovf_out(ovf13)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sat(input int v, input int w);
        int hi = (1 <<< (w - 1)) - 1;
        int lo = -(1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic step(input string tag, input bit v, input int p,
                        input bit clr = 1'b0, input bit ack = 1'b0, input bit r = 1'b0);
        int s;
        prod_valid_in = v;
        prod_in       = 12'(p);
        clear_in      = clr;
        ack_in        = ack;
        rst           = r;
        if (r || clr) begin
            m_done  = 1'b0;
            m_terms = 0;
            for (int k = 0; k < 2; k++) begin
                m_sum[k] = 0;
                m_ovf[k] = 1'b0;
            end
        end else if (m_done) begin
            if (ack) m_done = 1'b0;
        end else if (v) begin
            for (int k = 0; k < 2; k++) begin
                if (m_terms == 0) begin
                    m_sum[k] = p;
                    m_ovf[k] = 1'b0;
                end else begin
                    s = sat(m_sum[k] + p, m_w[k]);
                    if (s != m_sum[k] + p) m_ovf[k] = 1'b1;
                    m_sum[k] = s;
                end
            end
            m_terms++;
            if (m_terms == N) begin
                m_done  = 1'b1;
                m_terms = 0;
            end
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_sum16"},   int'($signed(sum16)), m_sum[0]);
        check_eq({tag, "_ovf16"},   int'(ovf16),          int'(m_ovf[0]));
        check_eq({tag, "_done16"},  int'(done16),         int'(m_done));
        check_eq({tag, "_ready16"}, int'(ready16),        int'(!m_done));
        check_eq({tag, "_sum13"},   int'($signed(sum13)), m_sum[1]);
        check_eq({tag, "_ovf13"},   int'(ovf13),          int'(m_ovf[1]));
        check_eq({tag, "_done13"},  int'(done13),         int'(m_done));
        check_eq({tag, "_ready13"}, int'(ready13),        int'(!m_done));
    endtask

    initial begin
        int tp1 [4] = '{100, -42, 25, 7};
        rst = 1'b1; prod_in = '0; prod_valid_in = 1'b0; clear_in = 1'b0; ack_in = 1'b0;
        m_done = 1'b0; m_terms = 0;
        for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_ovf[k] = 1'b0; end

        step("rst0", 0, 0, 0, 0, 1);
        step("rst1", 0, 0, 0, 0, 1);
        step("idle", 0, 0);

        // Back-to-back frame
        for (int i = 0; i < 4; i++) step("b2b", 1, tp1[i]);
        check_eq("tp1_sum", int'($signed(sum16)), 90);
        check_eq("tp1_done", int'(done16), 1);
        check_eq("tp1_ready", int'(ready16), 0);

        // Products offered while DONE must be ignored
        for (int i = 0; i < 3; i++) step("done_hold", 1, 5);
        step("ack", 0, 0, 0, 1);
        check_eq("ack_sum", int'($signed(sum16)), 90);
        check_eq("ack_ready", int'(ready16), 1);
        step("ack_outside", 0, 0, 0, 1);

        // Same frame with idle gaps
        for (int i = 0; i < 4; i++) begin
            int gaps = int'($urandom_range(3));
            for (int g = 0; g < gaps; g++) step("gap", 0, 0);
            step("gapped", 1, tp1[i]);
        end
        check_eq("tp2_sum", int'($signed(sum16)), 90);
        step("ack2", 0, 0, 0, 1);

        // Saturation in the 13-bit instance
        for (int i = 0; i < 4; i++) step("sat", 1, 1024);
        check_eq("tp3_sum13", int'($signed(sum13)), 4095);
        check_eq("tp3_ovf13", int'(ovf13), 1);
        step("ack3", 0, 0, 0, 1);
        check_eq("tp3_ovf_held", int'(ovf13), 1);
        step("ovf_clr", 1, 1);
        check_eq("tp3_ovf_cleared", int'(ovf13), 0);

        // Frame abort with a product presented on the clear cycle
        step("clr0", 0, 0, 1);
        step("abort", 1, 100);
        step("abort", 1, -42);
        step("abort_clr", 1, 7, 1);
        check_eq("tp5_sum", int'($signed(sum16)), 0);
        for (int i = 1; i <= 4; i++) step("fresh", 1, i);
        check_eq("tp5_fresh_sum", int'($signed(sum16)), 10);
        step("ack5", 0, 0, 0, 1);

        // Reset mid-frame
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 300);
        step("mid_rst", 0, 0, 0, 0, 1);
        check_eq("tp6_sum_rst", int'($signed(sum16)), 0);
        for (int i = 0; i < 4; i++) step("post_rst", 1, tp1[i]);
        check_eq("tp6_sum", int'($signed(sum16)), 90);

        // Random traffic, including full-scale negatives to hit the low clamp
        for (int i = 0; i < 400; i++) begin
            bit v   = ($urandom_range(9) < 7);
            int p   = int'($urandom_range(4095)) - 2048;
            bit clr = ($urandom_range(39) == 0);
            bit ack = ($urandom_range(1) == 0);
            bit r   = ($urandom_range(99) == 0);
            step("rand", v, p, clr, ack, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
